// File: rtl/kb_evq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// kb_evq_pkg : shared constants and types for the PS/2 keyboard event queue
// Revision   : 1.0
// ----------------------------------------------------------------------------
package kb_evq_pkg;

    localparam logic [31:0] OFS_DATA   = 32'h0;
    localparam logic [31:0] OFS_STATUS = 32'h4;

    localparam logic [7:0] CODE_EXT  = 8'hE0;
    localparam logic [7:0] CODE_BRK  = 8'hF0;
    localparam logic [7:0] CODE_ERR0 = 8'h00;
    localparam logic [7:0] CODE_ERRF = 8'hFF;

    localparam int EV_VALID = 31;
    localparam int EV_BRK   = 9;
    localparam int EV_EXT   = 8;

    localparam int WB_CLR_OVF = 8;
    localparam int WB_CLR_ERR = 9;
    localparam int WB_FLUSH   = 10;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_rx_frame.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ps2_rx_frame : synchronises the PS/2 lines and assembles checked 11-bit frames
// Revision     : 1.0
// ----------------------------------------------------------------------------
module ps2_rx_frame
    import kb_evq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_vld,
    output logic [7:0] data_byte,
    output logic       err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYC - 1);

    // Sync flops reset low so a line already held low after reset cannot fake an edge.
    logic [1:0] r_clk_sync;
    logic [1:0] r_data_sync;
    logic       r_clk_prev;
    logic       w_sample;

    rx_state_t     r_state, w_state;
    logic [2:0]    r_bit_cnt, w_bit_cnt;
    logic [7:0]    r_shift, w_shift;
    logic          r_par, w_par;
    logic [TW-1:0] r_tmo, w_tmo;
    logic          w_vld, w_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync  <= 2'b00;
            r_data_sync <= 2'b00;
            r_clk_prev  <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    assign w_sample = r_clk_prev & ~r_clk_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RX_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_par     <= 1'b0;
            r_tmo     <= '0;
            byte_vld  <= 1'b0;
            err       <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_bit_cnt <= w_bit_cnt;
            r_shift   <= w_shift;
            r_par     <= w_par;
            r_tmo     <= w_tmo;
            byte_vld  <= w_vld;
            err       <= w_err;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_bit_cnt = r_bit_cnt;
        w_shift   = r_shift;
        w_par     = r_par;
        w_tmo     = r_tmo;
        w_vld     = 1'b0;
        w_err     = 1'b0;
        if (w_sample) begin
            w_tmo = '0;
            case (r_state)
                RX_IDLE: begin
                    if (!r_data_sync[1]) begin
                        w_state   = RX_DATA;
                        w_bit_cnt = 3'd0;
                    end
                end
                RX_DATA: begin
                    w_shift   = {r_data_sync[1], r_shift[7:1]};
                    w_bit_cnt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7)
                        w_state = RX_PARITY;
                end
                RX_PARITY: begin
                    w_par   = r_data_sync[1];
                    w_state = RX_STOP;
                end
                RX_STOP: begin
                    w_state = RX_IDLE;
                    if (((^r_shift) ^ r_par) && r_data_sync[1])
                        w_vld = 1'b1;
                    else
                        w_err = 1'b1;
                end
                default: w_state = RX_IDLE;
            endcase
        end else if (r_state != RX_IDLE) begin
            if (r_tmo == C_TMO_LAST) begin
                w_state = RX_IDLE;
                w_tmo   = '0;
                w_err   = 1'b1;
            end else begin
                w_tmo = r_tmo + 1'b1;
            end
        end
    end

    // The shift register holds still in IDLE, so it is valid alongside byte_vld.
    assign data_byte = r_shift;

endmodule
`default_nettype wire

// File: rtl/ps2_kb_event_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ps2_kb_event_queue : memory-mapped PS/2 key event FIFO with E0/F0 prefix folding
// Revision           : 1.0
// ----------------------------------------------------------------------------
module ps2_kb_event_queue
    import kb_evq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'ha0001100,
    parameter int          DEPTH       = 16,
    parameter int          TIMEOUT_CYC = 100000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    input  logic [31:0] bus_addr,
    input  logic        bus_re,
    input  logic        bus_we,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq_pending
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);

    logic       w_byte_vld;
    logic       w_rx_err;
    logic [7:0] w_rx_byte;

    ps2_rx_frame #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk       (CLK),
        .rst_n     (RST_N),
        .ps2_clk   (PS2_CLK),
        .ps2_data  (PS2_DATA),
        .byte_vld  (w_byte_vld),
        .data_byte (w_rx_byte),
        .err       (w_rx_err)
    );

    logic r_ext, r_brk;
    logic w_is_ext, w_is_brk, w_is_errcode, w_emit, w_dec_err;

    assign w_is_ext     = w_byte_vld && (w_rx_byte == CODE_EXT);
    assign w_is_brk     = w_byte_vld && (w_rx_byte == CODE_BRK);
    assign w_is_errcode = (w_rx_byte == CODE_ERR0) || (w_rx_byte == CODE_ERRF);
    assign w_dec_err    = w_byte_vld && w_is_errcode;
    assign w_emit       = w_byte_vld && !w_is_ext && !w_is_brk && !w_is_errcode;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (w_emit) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else begin
            if (w_is_ext) r_ext <= 1'b1;
            if (w_is_brk) r_brk <= 1'b1;
        end
    end

    logic w_sel_data, w_sel_status, w_wr_status;
    logic w_clr_ovf, w_clr_err, w_flush;

    assign w_sel_data   = (bus_addr == BASE_ADDR + OFS_DATA);
    assign w_sel_status = (bus_addr == BASE_ADDR + OFS_STATUS);
    assign w_wr_status  = bus_we && w_sel_status;
    assign w_clr_ovf    = w_wr_status && bus_wdata[WB_CLR_OVF];
    assign w_clr_err    = w_wr_status && bus_wdata[WB_CLR_ERR];
    assign w_flush      = w_wr_status && bus_wdata[WB_FLUSH];

    logic [9:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [7:0]    r_err_cnt;
    logic          w_full, w_empty, w_pop, w_push;

    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);
    assign w_pop   = bus_re && w_sel_data && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push  = w_emit && (!w_full || w_pop);

    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {r_brk, r_ext, w_rx_byte};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_overflow <= 1'b0;
            r_err_cnt  <= 8'h00;
        end else begin
            if (w_clr_ovf)
                r_overflow <= 1'b0;
            else if (w_emit && w_full && !w_pop)
                r_overflow <= 1'b1;

            if (w_clr_err)
                r_err_cnt <= 8'h00;
            else if ((w_rx_err || w_dec_err) && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    logic [9:0]  w_head;
    logic [31:0] w_event_word;
    logic [31:0] w_status_word;

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_event_word           = 32'h0;
        w_event_word[EV_VALID] = 1'b1;
        w_event_word[EV_BRK]   = w_head[9];
        w_event_word[EV_EXT]   = w_head[8];
        w_event_word[7:0]      = w_head[7:0];
    end

    assign w_status_word = {8'h00, r_err_cnt, 7'h00, r_overflow, 8'(r_count)};

    always_comb begin
        bus_rdata = 32'h0;
        if (w_sel_data && !w_empty)
            bus_rdata = w_event_word;
        else if (w_sel_status)
            bus_rdata = w_status_word;
    end

    assign irq_pending = !w_empty;

    logic unused_wdata;
    assign unused_wdata = ^{bus_wdata[31:11], bus_wdata[7:0]};

endmodule
`default_nettype wire
